// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (A5, count, hi/lo word pairs) and writes it into
// instruction memory while holding the CPU in reset. Optional checksum byte: LOADER_CHECKSUM_EN.
`default_nettype none

module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [7:0] c_HEADER    = 8'hA5;
    localparam logic [8:0] c_MAX_WORDS = 9'(1 << ADDR_W);

    state_t              state_q;
    logic                rx_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [15:0]         imem_wdata_q;
    logic                cpu_hold_q;
    logic                load_done_q;
    logic                load_err_q;
    logic [ADDR_W:0]     words_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          hi_q;
    logic [8:0]          n_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                w_accept;
    logic [8:0]          w_n_eff;
    logic [8:0]          w_words_ext;
    logic                w_last;

    assign w_accept    = rx_valid & rx_ready_q;
    // A count byte of zero encodes the full 256-word frame.
    assign w_n_eff     = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
    assign w_words_ext = 9'(words_q);
    assign w_last      = ((w_words_ext + 9'd1) == n_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            words_q      <= '0;
            addr_q       <= '0;
            hi_q         <= '0;
            n_q          <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            rx_ready_q <= 1'b1;
            imem_we_q  <= 1'b0;
            if (w_accept) begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_data == c_HEADER) begin
                            state_q     <= S_COUNT;
                            cpu_hold_q  <= 1'b1;
                            load_done_q <= 1'b0;
                            load_err_q  <= 1'b0;
                        end
                    end
                    S_COUNT: begin
                        words_q <= '0;
                        addr_q  <= '0;
                        n_q     <= w_n_eff;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        if (w_n_eff > c_MAX_WORDS) begin
                            state_q     <= S_ERROR;
                            load_err_q  <= 1'b1;
                            load_done_q <= 1'b0;
                        end else begin
                            state_q <= S_HI;
                        end
                    end
                    S_HI: begin
                        hi_q    <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ rx_data;
`endif
                        state_q <= S_LO;
                    end
                    S_LO: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= addr_q;
                        imem_wdata_q <= {hi_q, rx_data};
                        words_q      <= words_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum_q       <= csum_q ^ rx_data;
`endif
                        // The address holds at N-1 after the last word so it never wraps.
                        if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= S_CHECK;
`else
                            state_q     <= S_DONE;
                            cpu_hold_q  <= 1'b0;
                            load_done_q <= 1'b1;
                            load_err_q  <= 1'b0;
`endif
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= S_HI;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (rx_data == csum_q) begin
                            state_q     <= S_DONE;
                            cpu_hold_q  <= 1'b0;
                            load_done_q <= 1'b1;
                            load_err_q  <= 1'b0;
                        end else begin
                            state_q     <= S_ERROR;
                            load_err_q  <= 1'b1;
                            load_done_q <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: an ADDR_W=8 instance and an ADDR_W=4 instance.
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid8 = 1'b0;
    logic        rx_valid4 = 1'b0;

    logic        rx_ready8, we8, hold8, done8, err8;
    logic [7:0]  addr8;
    logic [15:0] wdata8;
    logic [8:0]  words8;

    logic        rx_ready4, we4, hold4, done4, err4;
    logic [3:0]  addr4;
    logic [15:0] wdata4;
    logic [4:0]  words4;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid8),
        .rx_ready(rx_ready8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
        .cpu_hold(hold8), .load_done(done8), .load_err(err8), .words_loaded(words8)
    );

    imem_loader #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid4),
        .rx_ready(rx_ready4), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
        .cpu_hold(hold4), .load_done(done4), .load_err(err4), .words_loaded(words4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write logs captured mid-cycle.
    int          wr8 = 0;
    int          wr4 = 0;
    logic [7:0]  log_addr8 [0:511];
    logic [15:0] log_data8 [0:511];
    logic [3:0]  last_addr4 = '0;
    logic [15:0] last_data4 = '0;

    always @(negedge clk) begin
        if (we8) begin
            if (wr8 < 512) begin
                log_addr8[wr8] = addr8;
                log_data8[wr8] = wdata8;
            end
            wr8++;
        end
        if (we4) begin
            last_addr4 = addr4;
            last_data4 = wdata4;
            wr4++;
        end
    end

    task automatic send(input logic [7:0] b, input bit to4);
        rx_data = b;
        if (to4) rx_valid4 = 1'b1;
        else     rx_valid8 = 1'b1;
        @(posedge clk);
        #1;
        rx_valid8 = 1'b0;
        rx_valid4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int         stalls;
        int         bad;
        logic [7:0] kb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", rx_ready8, 0);
        check("rst_we", we8, 0);
        check("rst_addr", addr8, 0);
        check("rst_wdata", wdata8, 0);
        check("rst_hold", hold8, 0);
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        check("rst_words", words8, 0);
        check("rst_rx_ready4", rx_ready4, 0);
        reset = 1'b1;
        idle(1);
        check("ready_after_rst", rx_ready8, 1);

        // Two-word frame
        wr8 = 0;
        send(8'hA5, 0);
        check("hold_after_hdr", hold8, 1);
        send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h40, 0);
`endif
        idle(2);
        check("f1_wr_count", wr8, 2);
        check("f1_addr0", log_addr8[0], 0);
        check("f1_data0", log_data8[0], 16'h1234);
        check("f1_addr1", log_addr8[1], 1);
        check("f1_data1", log_data8[1], 16'hABCD);
        check("f1_done", done8, 1);
        check("f1_err", err8, 0);
        check("f1_words", words8, 2);
        check("f1_hold", hold8, 0);

        // Garbage before header is ignored
        wr8 = 0;
        send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
        idle(1);
        check("garbage_no_wr", wr8, 0);
        check("garbage_keeps_done", done8, 1);
        send(8'hA5, 0);
        check("hdr_clears_done", done8, 0);
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h01, 0);
`endif
        idle(2);
        check("f2_wr_count", wr8, 1);
        check("f2_addr0", log_addr8[0], 0);
        check("f2_data0", log_data8[0], 16'h0001);
        check("f2_done", done8, 1);
        check("f2_words", words8, 1);

        // ADDR_W=4: count 17 exceeds memory
        send(8'hA5, 1); send(8'h11, 1);
        idle(2);
        check("ovf_err", err4, 1);
        check("ovf_hold", hold4, 1);
        check("ovf_done", done4, 0);
        check("ovf_no_wr", wr4, 0);
        // ADDR_W=4: exactly 16 words fills memory
        send(8'hA5, 1);
        check("a4_hdr_clears_err", err4, 0);
        send(8'h10, 1);
        for (int k = 0; k < 16; k++) begin
            kb = 8'(k);
            send(kb, 1);
            send(~kb, 1);
        end
`ifdef LOADER_CHECKSUM_EN
        send(8'h00, 1);
`endif
        idle(2);
        check("a4_wr_count", wr4, 16);
        check("a4_last_addr", last_addr4, 15);
        check("a4_last_data", last_data4, 16'h0FF0);
        check("a4_words", words4, 16);
        check("a4_done", done4, 1);
        check("a4_hold", hold4, 0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum
        wr8 = 0;
        send(8'hA5, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 0);
        idle(2);
        check("cs_wr_count", wr8, 1);
        check("cs_data0", log_data8[0], 16'h1234);
        check("cs_err", err8, 1);
        check("cs_hold", hold8, 1);
        send(8'hA5, 0);
        check("cs_hdr_clears_err", err8, 0);
`endif

        // Reset mid-load
        wr8 = 0;
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0);
        reset = 1'b0;
        #2;
        check("mid_rst_ready", rx_ready8, 0);
        check("mid_rst_hold", hold8, 0);
        check("mid_rst_words", words8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_err", err8, 0);
        idle(2);
        reset = 1'b1;
        idle(1);
        check("mid_rst_no_wr", wr8, 0);
        send(8'hA5, 0); send(8'h01, 0); send(8'hBE, 0); send(8'hEF, 0);
`ifdef LOADER_CHECKSUM_EN
        send(8'h51, 0);
`endif
        idle(2);
        check("rl_wr_count", wr8, 1);
        check("rl_data0", log_data8[0], 16'hBEEF);
        check("rl_done", done8, 1);

        // Full 256-word frame, streamed without gaps
        wr8 = 0;
        stalls = 0;
        send(8'hA5, 0);
        send(8'h00, 0);
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            if (!rx_ready8) stalls++;
            send(kb, 0);
            if (!rx_ready8) stalls++;
            send(~kb, 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send(8'h00, 0);
`endif
        idle(2);
        check("full_wr_count", wr8, 256);
        check("full_stalls", stalls, 0);
        check("full_words", words8, 256);
        check("full_done", done8, 1);
        check("full_addr255", log_addr8[255], 255);
        check("full_data0", log_data8[0], 16'h00FF);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            if (log_addr8[k] !== kb || log_data8[k] !== {kb, ~kb}) bad++;
        end
        check("full_all_entries_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width; legal range 4..8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 rx_data  input  8  received byte from the serial front end.
REQ-005 rx_valid  input  1  rx_data valid this cycle.
REQ-006 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1 at a rising edge.
REQ-007 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 imem_addr  output  ADDR_W  write address.
REQ-009 imem_wdata  output  16  instruction word written.
REQ-010 cpu_hold  output  1  holds the CPU (controller and datapath) in reset while 1.
REQ-011 load_done  output  1  last load completed successfully.
REQ-012 load_err  output  1  last load failed.
REQ-013 words_loaded  output  ADDR_W+1  words written in the current or last load.

Function
REQ-014 Frame format: header 0xA5, count byte N, then N words of two bytes each (high byte first), then an optional checksum byte (REQ-031).
REQ-015 N = 0 SHALL mean 256 words; an effective N greater than 2^ADDR_W SHALL go to ERROR immediately after the count byte.
REQ-016 States: IDLE, COUNT, HI, LO, CHECK, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR: byte 0xA5 -> COUNT; any other byte is discarded and the state is unchanged.
REQ-018 COUNT: accepted byte -> HI (or ERROR per REQ-015); clear words_loaded, address counter and checksum.
REQ-019 HI: the accepted byte is latched as the upper byte -> LO.
REQ-020 LO: the accepted byte completes the word; on the next cycle imem_we=1 for exactly one cycle, with imem_addr = the address counter and imem_wdata = {hi, lo}.
REQ-021 After each write, the address counter and words_loaded increment by 1; the last word goes to CHECK (if enabled) or DONE, otherwise back to HI.
REQ-022 The address counter SHALL never wrap within a load; the last address is N-1.
REQ-023 rx_ready = 1 in every state once out of reset; latency is one byte per cycle, sustained.
REQ-024 cpu_hold rises in the cycle after 0xA5 is accepted and stays 1 through COUNT, HI, LO and CHECK.
REQ-025 Entering DONE: cpu_hold=0, load_done=1, load_err=0.
REQ-026 Entering ERROR: cpu_hold stays 1, load_err=1, load_done=0.
REQ-027 A new 0xA5 accepted in DONE or ERROR clears load_done and load_err and starts a new load.
REQ-028 A back-to-back byte accepted in the same cycle that imem_we is high SHALL be processed normally, with no loss.

Reset
REQ-029 While reset=0: state=IDLE; rx_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=0; load_done=0; load_err=0; words_loaded=0; checksum=0.
REQ-030 Reset asserted mid-load aborts immediately with no further writes; partial memory contents are left as they are.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN, when defined:
- a running XOR of all 2N data bytes is kept;
- after the last word the state goes to CHECK, and the next byte is compared with the running XOR;
- equal -> DONE; unequal -> ERROR.
REQ-032 When LOADER_CHECKSUM_EN is undefined: there is no CHECK state and no checksum register; the last word goes directly to DONE.

Verification
REQ-033 Bytes A5,02,12,34,AB,CD (checksum 40 if enabled) -> writes (0,0x1234), (1,0xABCD); load_done=1; words_loaded=2; cpu_hold=0.
REQ-034 Garbage 00,FF,5A before A5,01,00,01 (checksum 01) -> garbage ignored, no writes; then a single write (0,0x0001); load_done=1.
REQ-035 ADDR_W=4, bytes A5,11 -> ERROR; load_err=1; cpu_hold=1; no imem_we pulse.
REQ-036 LOADER_CHECKSUM_EN defined, bytes A5,01,12,34,00 -> one write (0,0x1234), then load_err=1 and cpu_hold=1; a following A5 clears load_err.
REQ-037 reset low after A5,02,12 -> all outputs at reset values, no write; after release, a complete frame loads correctly.
REQ-038 ADDR_W=8, count 00, 512 bytes at rx_valid=1 continuously -> 256 writes to addresses 0..255 with no stall; words_loaded=256.
